// File: rtl/cellar_pkg.sv
// Shared types and constants for the wine-cellar thermostat.
package cellar_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    HEAT  = 3'd2,
    COOL  = 3'd3,
    ALARM = 3'd4
  } state_t;

  localparam logic [1:0] LED_OFF   = 2'b00;
  localparam logic [1:0] LED_HEAT  = 2'b01;
  localparam logic [1:0] LED_COOL  = 2'b10;
  localparam logic [1:0] LED_ALARM = 2'b11;

  localparam logic [4:0] DTF_MAX = 5'd31;

  function automatic logic [1:0] led_code(state_t s);
    case (s)
      HEAT:    return LED_HEAT;
      COOL:    return LED_COOL;
      ALARM:   return LED_ALARM;
      default: return LED_OFF;
    endcase
  endfunction

endpackage

// File: rtl/cellar_temp_model.sv
// Cellar temperature model: steps RTR while heating/cooling, otherwise drifts toward ambient.
module cellar_temp_model
  import cellar_pkg::*;
#(
  parameter int RTR_INIT     = 20,
  parameter int AMBIENT      = 20,
  parameter int STEP_CYCLES  = 10,
  parameter int DRIFT_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  state_t     mode,
  output logic [5:0] rtr
);

  localparam int TMAX = (DRIFT_CYCLES > STEP_CYCLES) ? DRIFT_CYCLES : STEP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [5:0] AMB = 6'(AMBIENT);

  state_t          mode_q;
  logic            active;
  logic [TW-1:0]   limit;
  logic [TW-1:0]   cnt;
  logic [TW-1:0]   cnt_eff;

  assign active = (mode == HEAT) || (mode == COOL);
  assign limit  = active ? TW'(STEP_CYCLES - 1) : TW'(DRIFT_CYCLES - 1);
  // A mode change restarts the period in the same cycle, so no extra cycle is lost.
  assign cnt_eff = (mode != mode_q) ? '0 : cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q <= IDLE;
      cnt    <= '0;
      rtr    <= 6'(RTR_INIT);
    end else begin
      mode_q <= mode;
      if (cnt_eff == limit) begin
        cnt <= '0;
        case (mode)
          HEAT:    if (rtr != 6'd63) rtr <= rtr + 6'd1;
          COOL:    if (rtr != 6'd0)  rtr <= rtr - 6'd1;
          default: begin
            if (rtr < AMB)      rtr <= rtr + 6'd1;
            else if (rtr > AMB) rtr <= rtr - 6'd1;
          end
        endcase
      end else begin
        cnt <= cnt_eff + 1'b1;
      end
    end
  end

endmodule

// File: rtl/top_module_cellar.sv
// Wine-cellar thermostat top: target register, regulation FSM, alarm and LED decode.
// state | meaning
// IDLE  | not regulating; temperature drifts to ambient
// HOLD  | at target, within hysteresis band
// HEAT  | raising temperature toward target
// COOL  | lowering temperature toward target
// ALARM | door opened while regulating; waits for restart with door closed
module top_module_cellar
  import cellar_pkg::*;
#(
  parameter int RTR_INIT     = 20,
  parameter int AMBIENT      = 20,
  parameter int STEP_CYCLES  = 10,
  parameter int DRIFT_CYCLES = 50,
  parameter int HYST         = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] DT,
  input  logic       CONF,
  input  logic       INCR,
  input  logic       DECR,
  input  logic       SS,
  input  logic       ST,
  input  logic       nWS,
  input  logic       restart,
  output logic [4:0] DTF,
  output logic [5:0] RTR,
  output logic       WS,
  output logic [1:0] LED
);

  state_t     state, state_nxt;
  logic       incr_q, decr_q;
  logic       inc_edge, dec_edge;
  logic       run;
  logic [6:0] rtr7, dtf7, hyst7;

  assign inc_edge = INCR & ~incr_q;
  assign dec_edge = DECR & ~decr_q;
  assign run      = SS & ST & nWS;
  // 7-bit compares keep RTR+HYST from wrapping near the top of the range.
  assign rtr7     = {1'b0, RTR};
  assign dtf7     = {2'b00, DTF};
  assign hyst7    = 7'(HYST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      DTF    <= '0;
      incr_q <= 1'b0;
      decr_q <= 1'b0;
    end else begin
      incr_q <= INCR;
      decr_q <= DECR;
      if (CONF)
        DTF <= DT;
      else if (inc_edge && !dec_edge && DTF != DTF_MAX)
        DTF <= DTF + 5'd1;
      else if (dec_edge && !inc_edge && DTF != 5'd0)
        DTF <= DTF - 5'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ALARM) begin
      if (restart && nWS) state_nxt = IDLE;
    end else if (state != IDLE && !nWS) begin
      state_nxt = ALARM;
    end else if (restart || !SS) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (run) begin
          if (rtr7 < dtf7)      state_nxt = HEAT;
          else if (rtr7 > dtf7) state_nxt = COOL;
          else                  state_nxt = HOLD;
        end
        HEAT: begin
          if (!ST)               state_nxt = IDLE;
          else if (rtr7 >= dtf7) state_nxt = HOLD;
        end
        COOL: begin
          if (!ST)               state_nxt = IDLE;
          else if (rtr7 <= dtf7) state_nxt = HOLD;
        end
        HOLD: begin
          if (!ST)                       state_nxt = IDLE;
          else if (rtr7 + hyst7 < dtf7)  state_nxt = HEAT;
          else if (rtr7 > dtf7 + hyst7)  state_nxt = COOL;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      WS    <= 1'b0;
      LED   <= LED_OFF;
    end else begin
      state <= state_nxt;
      WS    <= (state_nxt == ALARM);
      LED   <= led_code(state_nxt);
    end
  end

  cellar_temp_model #(
    .RTR_INIT     (RTR_INIT),
    .AMBIENT      (AMBIENT),
    .STEP_CYCLES  (STEP_CYCLES),
    .DRIFT_CYCLES (DRIFT_CYCLES)
  ) u_temp (
    .clk  (clk),
    .rst  (rst),
    .mode (state),
    .rtr  (RTR)
  );

endmodule

// File: tb/tb_top_module_cellar.sv
// Directed bench for the cellar thermostat top.
module tb_top_module_cellar;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] dt;
  logic       conf, incr, decr, ss, st, nws, restart;
  logic [4:0] dtf;
  logic [5:0] rtr;
  logic       ws;
  logic [1:0] led;

  int n_tests = 0;
  int n_fail  = 0;

  top_module_cellar dut (
    .clk     (clk),
    .rst     (rst),
    .DT      (dt),
    .CONF    (conf),
    .INCR    (incr),
    .DECR    (decr),
    .SS      (ss),
    .ST      (st),
    .nWS     (nws),
    .restart (restart),
    .DTF     (dtf),
    .RTR     (rtr),
    .WS      (ws),
    .LED     (led)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_dtf(input logic [4:0] v);
    dt = v; conf = 1'b1;
    tick(2);
    conf = 1'b0;
  endtask

  task automatic pulse_incr();
    incr = 1'b1; tick(); incr = 1'b0; tick();
  endtask

  task automatic pulse_decr();
    decr = 1'b1; tick(); decr = 1'b0; tick();
  endtask

  initial begin
    int waited;
    rst = 1'b0; dt = '0; conf = 0; incr = 0; decr = 0;
    ss = 0; st = 0; nws = 1; restart = 0;

    // 1: reset
    tick(2);
    chk("rst_dtf", dtf, 0);
    chk("rst_rtr", rtr, 20);
    chk("rst_ws",  ws,  0);
    chk("rst_led", led, 0);
    rst = 1'b1;

    // 2: target register
    dt = 5'd8; conf = 1'b1; tick(15); conf = 1'b0;
    chk("conf_dtf", dtf, 8);
    pulse_incr(); pulse_incr(); pulse_decr();
    chk("incdec_dtf", dtf, 9);
    incr = 1'b1; tick(20); incr = 1'b0; tick();
    chk("incr_held", dtf, 10);
    set_dtf(5'd31); pulse_incr();
    chk("incr_sat", dtf, 31);
    incr = 1'b1; decr = 1'b1; tick(); incr = 1'b0; decr = 1'b0; tick();
    chk("both_edges", dtf, 31);
    set_dtf(5'd0); pulse_decr();
    chk("decr_sat", dtf, 0);

    // 3: cooling to 8, hold, drift back up to DTF+HYST+1
    set_dtf(5'd8);
    ss = 1; st = 1; nws = 1;
    tick();
    chk("cool_led", led, 2);
    tick(119);
    chk("cool_rtr119", rtr, 9);
    tick();
    chk("cool_rtr120", rtr, 8);
    chk("cool_led120", led, 2);
    tick();
    chk("hold_led", led, 0);
    tick(100);
    chk("drift_rtr", rtr, 10);
    chk("hold_band", led, 0);
    tick();
    chk("recool_led", led, 2);

    // 4: alarm
    nws = 1'b0; tick();
    chk("alarm_ws",  ws,  1);
    chk("alarm_led", led, 3);
    restart = 1'b1; tick(3);
    chk("alarm_held_ws",  ws,  1);
    chk("alarm_held_led", led, 3);
    nws = 1'b1; tick();
    chk("clear_ws",  ws,  0);
    chk("clear_led", led, 0);
    restart = 1'b0; tick();
    chk("resume_led", led, 2);

    // 5: switched off, drift to ambient, door ignored
    ss = 1'b0; tick();
    chk("off_led", led, 0);
    nws = 1'b0; tick(5);
    chk("idle_door_ws", ws, 0);
    waited = 0;
    while (rtr != 6'd20 && waited < 700) begin
      tick(); waited++;
    end
    chk("drift_ambient", rtr, 20);
    tick(100);
    chk("ambient_stable", rtr, 20);
    chk("idle_door_ws2", ws, 0);
    chk("idle_door_led", led, 0);
    nws = 1'b1;

    // 6: heating, then reset mid-heat
    set_dtf(5'd25);
    ss = 1; st = 1;
    tick();
    chk("heat_led", led, 1);
    tick(49);
    chk("heat_rtr49", rtr, 24);
    tick();
    chk("heat_rtr50", rtr, 25);
    tick();
    chk("heat_hold_led", led, 0);
    set_dtf(5'd30);
    tick();
    chk("reheat_led", led, 1);
    tick(15);
    chk("reheat_rtr", rtr, 26);
    rst = 1'b0; tick();
    chk("midrst_dtf", dtf, 0);
    chk("midrst_rtr", rtr, 20);
    chk("midrst_ws",  ws,  0);
    chk("midrst_led", led, 0);
    rst = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
